// File: rtl/ball_key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ball_key_ctrl_pkg
//  Purpose  : Shared scan-code constants, prefix-decoder state encoding and
//             screen-size defaults for the keyboard-driven ball controller.
//  Revision : 1.0 - initial release
// ============================================================================
package ball_key_ctrl_pkg;

   // PS/2 set-2 scan codes used by the controller
   localparam logic [7:0] c_code_ext   = 8'hE0;
   localparam logic [7:0] c_code_brk   = 8'hF0;
   localparam logic [7:0] c_code_up    = 8'h75;
   localparam logic [7:0] c_code_down  = 8'h72;
   localparam logic [7:0] c_code_left  = 8'h6B;
   localparam logic [7:0] c_code_right = 8'h74;
   localparam logic [7:0] c_code_c     = 8'h21;

   // Screen-size defaults
   localparam int c_scr_w_def = 640;
   localparam int c_scr_h_def = 480;

   // Prefix decoder states
   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_EXT     = 2'd1,
      ST_BRK     = 2'd2,
      ST_EXT_BRK = 2'd3
   } scan_state_t;

   // Maps an extended arrow-key code onto its {up,down,left,right} flag
   function automatic logic [3:0] arrow_mask(input logic [7:0] code);
      logic [3:0] mask;
      mask = 4'b0000;
      case (code)
         c_code_up:    mask = 4'b1000;
         c_code_down:  mask = 4'b0100;
         c_code_left:  mask = 4'b0010;
         c_code_right: mask = 4'b0001;
         default:      mask = 4'b0000;
      endcase
      return mask;
   endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : ps2_scan_decoder
//  Purpose  : Tracks the E0/F0 prefix sequence of PS/2 scan codes, keeps the
//             arrow-key held flags and flags make/break of the 'C' key.
//  Revision : 1.0 - initial release
// ============================================================================
module ps2_scan_decoder
   import ball_key_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] i_code,
   input  logic       i_code_valid,
   output logic [3:0] o_held,
   output logic       o_c_make,
   output logic       o_c_break
);

   scan_state_t state_q, state_d;
   logic [3:0]  held_q, held_d;

   // Prefix state and held flags; a reset mid-sequence discards the prefix
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         held_q  <= 4'b0000;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
      end
   end

   // Next state, arrow-flag updates and 'C' make/break strobes
   always_comb begin
      state_d   = state_q;
      held_d    = held_q;
      o_c_make  = 1'b0;
      o_c_break = 1'b0;
      if (i_code_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (i_code == c_code_ext) begin
                  state_d = ST_EXT;
               end else if (i_code == c_code_brk) begin
                  state_d = ST_BRK;
               end else begin
                  state_d  = ST_IDLE;
                  o_c_make = (i_code == c_code_c);
               end
            end
            ST_EXT: begin
               if (i_code == c_code_brk) begin
                  state_d = ST_EXT_BRK;
               end else if (i_code == c_code_ext) begin
                  state_d = ST_EXT;
               end else begin
                  state_d = ST_IDLE;
                  held_d  = held_q | arrow_mask(i_code);
               end
            end
            ST_BRK: begin
               state_d   = ST_IDLE;
               o_c_break = (i_code == c_code_c);
            end
            ST_EXT_BRK: begin
               state_d = ST_IDLE;
               held_d  = held_q & ~arrow_mask(i_code);
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign o_held = held_q;

endmodule
`default_nettype wire

// File: rtl/ball_key_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ball_key_ctrl
//  Purpose  : Moves a ball on screen from PS/2 arrow keys, clamping it inside
//             a radius-dependent border, and cycles its colour with 'C'.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_key_ctrl
   import ball_key_ctrl_pkg::*;
#(
   parameter int SCR_W    = c_scr_w_def,
   parameter int SCR_H    = c_scr_h_def,
   parameter int STEP     = 4,
   parameter int RAD_UNIT = 8
) (
   input  logic        CLK,
   input  logic        reset,
   input  logic [7:0]  code,
   input  logic        code_valid,
   input  logic        move_tick,
   input  logic [2:0]  radius,
   output logic [1:0]  color,
   output logic [10:0] ball_x,
   output logic [10:0] ball_y,
   output logic [3:0]  held
);

   logic [3:0]  held_w;
   logic        c_make;
   logic        c_break;

   logic [1:0]  color_q, color_d;
   logic        c_held_q, c_held_d;
   logic [10:0] ball_x_q, ball_x_d;
   logic [10:0] ball_y_q, ball_y_d;

   logic [10:0]        rpix;
   logic signed [11:0] step_s, lo_s, x_hi_s, y_hi_s;
   logic signed [11:0] dx_s, dy_s, x_mov_s, y_mov_s, x_clamp_s, y_clamp_s;

   ps2_scan_decoder u_decoder (
      .clk          (CLK),
      .rst          (reset),
      .i_code       (code),
      .i_code_valid (code_valid),
      .o_held       (held_w),
      .o_c_make     (c_make),
      .o_c_break    (c_break)
   );

   // Colour, C-held latch and ball position registers
   always_ff @(posedge CLK or posedge reset) begin
      if (reset) begin
         color_q  <= 2'd0;
         c_held_q <= 1'b0;
         ball_x_q <= 11'(SCR_W / 2);
         ball_y_q <= 11'(SCR_H / 2);
      end else begin
         color_q  <= color_d;
         c_held_q <= c_held_d;
         ball_x_q <= ball_x_d;
         ball_y_q <= ball_y_d;
      end
   end

   // Colour steps only on the first make of 'C'; typematic repeats are ignored
   always_comb begin
      color_d  = color_q;
      c_held_d = c_held_q;
      if (c_make && !c_held_q) begin
         color_d  = color_q + 2'd1;
         c_held_d = 1'b1;
      end
      if (c_break) begin
         c_held_d = 1'b0;
      end
   end

   // Motion plus clamp; signed 12-bit math keeps X-STEP from wrapping below 0
   always_comb begin
      rpix   = (11'(radius) + 11'd1) * 11'(RAD_UNIT);
      step_s = 12'(STEP);
      lo_s   = signed'({1'b0, rpix});
      x_hi_s = 12'(SCR_W - 1) - lo_s;
      y_hi_s = 12'(SCR_H - 1) - lo_s;

      // held is {up,down,left,right}; opposite keys together cancel
      case ({held_w[0], held_w[1]})
         2'b10:   dx_s = step_s;
         2'b01:   dx_s = -step_s;
         default: dx_s = 12'sd0;
      endcase
      case ({held_w[2], held_w[3]})
         2'b10:   dy_s = step_s;
         2'b01:   dy_s = -step_s;
         default: dy_s = 12'sd0;
      endcase

      x_mov_s = signed'({1'b0, ball_x_q}) + dx_s;
      y_mov_s = signed'({1'b0, ball_y_q}) + dy_s;

      if (x_mov_s < lo_s)        x_clamp_s = lo_s;
      else if (x_mov_s > x_hi_s) x_clamp_s = x_hi_s;
      else                       x_clamp_s = x_mov_s;

      if (y_mov_s < lo_s)        y_clamp_s = lo_s;
      else if (y_mov_s > y_hi_s) y_clamp_s = y_hi_s;
      else                       y_clamp_s = y_mov_s;

      // Clamp is applied on every tick so a radius increase pulls the ball in
      ball_x_d = move_tick ? x_clamp_s[10:0] : ball_x_q;
      ball_y_d = move_tick ? y_clamp_s[10:0] : ball_y_q;
   end

   assign color  = color_q;
   assign ball_x = ball_x_q;
   assign ball_y = ball_y_q;
   assign held   = held_w;

endmodule
`default_nettype wire

// File: doc/ball_key_ctrl.md
BALL_KEY_CTRL -- requirements
Module: ball_key_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- SCR_W, 640, screen width in pixels.
- SCR_H, 480, screen height in pixels.
- STEP, 4, pixels moved per move_tick per axis.
- RAD_UNIT, 8, pixels per radius step.

REQ-002 Ports, one per line: name, direction, width, meaning.
- CLK, in, 1, single system clock; all logic on posedge CLK.
- reset, in, 1, asynchronous, active-high.
- code, in, 8, PS/2 scan-code byte.
- code_valid, in, 1, one-cycle strobe qualifying code.
- move_tick, in, 1, one-cycle frame-rate movement strobe.
- radius, in, 3, ball radius index.
- color, out, 2, ball colour index.
- ball_x, out, 11, ball centre X.
- ball_y, out, 11, ball centre Y.
- held, out, 4, {up,down,left,right} key-held flags.

Function
REQ-003 Prefix decoder SHALL be a 4-state FSM: IDLE, EXT (after E0), BRK (after F0), EXT_BRK (after E0 F0); it advances only on code_valid.
REQ-004 Transitions SHALL be: IDLE: E0->EXT, F0->BRK, other->IDLE (make). EXT: F0->EXT_BRK, E0->EXT, other->IDLE (extended make). BRK: any->IDLE (break). EXT_BRK: any->IDLE (extended break).
REQ-005 Extended make/break of 75/72/6B/74 SHALL set/clear held[3]/[2]/[1]/[0] (up/down/left/right) one cycle after the code_valid that completes the sequence.
REQ-006 Non-extended make of 0x21 ('C') SHALL increment color modulo 4 (3->0) only if C is not already held; break of 0x21 SHALL clear C-held; typematic repeats SHALL NOT increment.
REQ-007 Unrecognised codes SHALL return the FSM to IDLE with no other effect.
REQ-008 Effective radius rpix SHALL be (radius+1)*RAD_UNIT, computed at 11 bits.
REQ-009 On move_tick, ball_x SHALL gain +STEP if right-only held, -STEP if left-only held, else unchanged; ball_y likewise with down (+) and up (-); both-opposite held SHALL mean no motion on that axis.
REQ-010 Result SHALL be clamped to [rpix, SCR_W-1-rpix] for X and [rpix, SCR_H-1-rpix] for Y, using signed 12-bit intermediates so no wrap-around below 0 occurs.
REQ-011 Clamping SHALL be applied on every move_tick even with no key held, so a radius increase pulls the ball inside the bounds.
REQ-012 Position SHALL update exactly one cycle after move_tick.
REQ-013 Simultaneous code_valid and move_tick SHALL both be processed; motion SHALL use held as registered before that edge.

Reset
REQ-014 While reset is high, regardless of CLK, outputs SHALL be: FSM=IDLE, held=0, C-held=0, color=0, ball_x=SCR_W/2 (320), ball_y=SCR_H/2 (240).
REQ-015 Reset asserted mid-sequence (e.g. after E0) SHALL discard the partial prefix; the first byte after release SHALL be decoded from IDLE.

Structure
REQ-016 A shared package SHALL hold scan-code constants (E0, F0, 75, 72, 6B, 74, 21), the FSM state encoding, and the screen-size defaults.
REQ-017 The prefix FSM plus held-flag logic SHALL be sub-module ps2_scan_decoder; ball_key_ctrl SHALL contain the motion, clamp and colour logic.

Verification
REQ-018 Reset release, no input -> ball_x=320, ball_y=240, color=0, held=0.
REQ-019 Send E0,74, then 10 move_ticks, then E0,F0,74, then 2 ticks -> ball_x=360, ball_y=240, held=0.
REQ-020 Send 21, 21, 21 (typematic), F0,21, 21 -> color=2.
REQ-021 radius=7 (rpix=64), hold E0,6B, 100 ticks -> ball_x saturates at 64 and never goes below it; then radius=0 plus ticks -> ball_x=8 reached in STEP decrements.
REQ-022 Hold E0,6B and E0,74 together, 5 ticks -> ball_x unchanged; code_valid and move_tick in the same cycle -> motion reflects held from before that edge.
REQ-023 Assert reset after E0 alone, release, send 75 -> no held bit set; then E0,75 plus 1 tick -> ball_y=236.
